tx_dbf_ch: RTL and testbench

- Per-channel transmit beamforming delay and pulse generator; the transmit-side counterpart of the per-channel receive delay path.
- On a line fire command it looks up the channel's transmit focusing delay from a dual-port delay LUT, waits that many clocks, then drives a bipolar pulse burst to the pulser gates.
- It asserts tx_en for the whole transmit window; tx_en feeds the receive channel's input-valid gating.
- One instance per array element, driven by a common fire/line controller.

---
 rtl/tx_dbf_ch.sv | 246 ++++++++++++++++++++++++
 tb/tb_tx_dbf_ch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_dbf_ch.sv
// Per-channel transmit beamforming delay and bipolar pulse burst generator.
// Optional macro TX_RTZ_EN adds the pulse_clamp output and dead-time slots between gate phases.
module tx_dbf_ch #(
   parameter int ADDR_WD  = 7,
   parameter int DLY_WD   = 12,
   parameter int CYC_WD   = 4,
   parameter int HP_WD    = 8,
   parameter int DAMP_CLK = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_WD-1:0] lut_addr,
   input  logic [DLY_WD-1:0]  lut_din,
   input  logic               lut_we,
   input  logic [ADDR_WD-1:0] line_sel,
   input  logic               fire,
   input  logic [CYC_WD-1:0]  num_cycles,
   input  logic [HP_WD-1:0]   half_period,
   input  logic               abort,
   output logic               pulse_p,
   output logic               pulse_n,
   output logic               tx_en,
   output logic               busy,
`ifdef TX_RTZ_EN
   output logic               pulse_clamp,
`endif
   output logic               done
);

   localparam int DEPTH  = 1 << ADDR_WD;
   localparam int DMP_WD = $clog2(DAMP_CLK + 1);
`ifdef TX_RTZ_EN
   localparam bit RTZ = 1'b1;
`else
   localparam bit RTZ = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_PULSE = 3'd3,
      S_DAMP  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PH_P  = 2'd0,
      PH_DP = 2'd1,
      PH_N  = 2'd2,
      PH_DN = 2'd3
   } phase_t;

   logic [DLY_WD-1:0] mem_r [DEPTH];
   logic [DLY_WD-1:0] lut_q_r;

   state_t             state_r, state_s;
   phase_t             phase_r, phase_s;
   logic [DLY_WD-1:0]  dly_r, dly_s;
   logic [CYC_WD-1:0]  cyc_r, cyc_s, nc_r, nc_s;
   logic [HP_WD-1:0]   hpc_r, hpc_s, hp_r, hp_s;
   logic [DMP_WD-1:0]  damp_r, damp_s;
   logic               go_s;
   logic               busy_s, pp_s, pn_s, done_s, clamp_s;
   logic               pulse_p_r, pulse_n_r, busy_r, done_r, clamp_r;

   // Delay LUT write port; memory contents are not reset.
   always_ff @(posedge clk) begin
      if (lut_we) begin
         mem_r[lut_addr] <= lut_din;
      end
   end

   // Delay LUT read port: addressed by line_sel so the fire cycle issues the read (read-before-write).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_q_r <= '0;
      end else begin
         lut_q_r <= mem_r[line_sel];
      end
   end

   // Next-state, counter and registered-output decode.
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      dly_s   = dly_r;
      cyc_s   = cyc_r;
      nc_s    = nc_r;
      hpc_s   = hpc_r;
      hp_s    = hp_r;
      damp_s  = damp_r;
      go_s    = 1'b0;

      if (abort) begin
         state_s = S_IDLE;
         phase_s = PH_P;
         dly_s   = '0;
         cyc_s   = '0;
         hpc_s   = '0;
         damp_s  = '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (fire) begin
                  state_s = S_FETCH;
                  nc_s    = num_cycles;
                  hp_s    = (half_period == '0) ? HP_WD'(1) : half_period;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_FETCH: begin
               if (lut_q_r == '0) begin
                  go_s = 1'b1;
               end else begin
                  state_s = S_WAIT;
                  dly_s   = lut_q_r;
               end
            end
            S_WAIT: begin
               if (dly_r == DLY_WD'(1)) begin
                  go_s  = 1'b1;
                  dly_s = '0;
               end else begin
                  dly_s = dly_r - DLY_WD'(1);
               end
            end
            S_PULSE: begin
               case (phase_r)
                  PH_P: begin
                     if (hpc_r == HP_WD'(1)) begin
                        phase_s = RTZ ? PH_DP : PH_N;
                        hpc_s   = hp_r;
                     end else begin
                        hpc_s = hpc_r - HP_WD'(1);
                     end
                  end
                  PH_DP: begin
                     phase_s = PH_N;
                     hpc_s   = hp_r;
                  end
                  PH_N: begin
                     if (hpc_r != HP_WD'(1)) begin
                        hpc_s = hpc_r - HP_WD'(1);
                     end else if (cyc_r == CYC_WD'(1)) begin
                        state_s = S_DAMP;
                        phase_s = PH_P;
                        damp_s  = DMP_WD'(DAMP_CLK);
                     end else begin
                        cyc_s   = cyc_r - CYC_WD'(1);
                        phase_s = RTZ ? PH_DN : PH_P;
                        hpc_s   = hp_r;
                     end
                  end
                  PH_DN: begin
                     phase_s = PH_P;
                     hpc_s   = hp_r;
                  end
                  default: begin
                     phase_s = PH_P;
                  end
               endcase
            end
            S_DAMP: begin
               if (damp_r == DMP_WD'(1)) begin
                  state_s = S_IDLE;
                  damp_s  = '0;
               end else begin
                  damp_s = damp_r - DMP_WD'(1);
               end
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase

         // Shared WAIT exit: start the burst, or go straight to damping for an empty burst.
         if (go_s) begin
            if (nc_r == '0) begin
               state_s = S_DAMP;
               damp_s  = DMP_WD'(DAMP_CLK);
            end else begin
               state_s = S_PULSE;
               phase_s = PH_P;
               hpc_s   = hp_r;
               cyc_s   = nc_r;
            end
         end else begin
            go_s = 1'b0;
         end
      end

      busy_s  = (state_s != S_IDLE);
      pp_s    = (state_s == S_PULSE) && (phase_s == PH_P);
      pn_s    = (state_s == S_PULSE) && (phase_s == PH_N);
      done_s  = (state_s == S_DAMP) && (damp_s == DMP_WD'(1));
      clamp_s = (state_s == S_DAMP) ||
                ((state_s == S_PULSE) && ((phase_s == PH_DP) || (phase_s == PH_DN)));
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         phase_r   <= PH_P;
         dly_r     <= '0;
         cyc_r     <= '0;
         nc_r      <= '0;
         hpc_r     <= '0;
         hp_r      <= '0;
         damp_r    <= '0;
         pulse_p_r <= 1'b0;
         pulse_n_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         clamp_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         phase_r   <= phase_s;
         dly_r     <= dly_s;
         cyc_r     <= cyc_s;
         nc_r      <= nc_s;
         hpc_r     <= hpc_s;
         hp_r      <= hp_s;
         damp_r    <= damp_s;
         pulse_p_r <= pp_s;
         pulse_n_r <= pn_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         clamp_r   <= clamp_s && RTZ;
      end
   end

   assign pulse_p = pulse_p_r;
   assign pulse_n = pulse_n_r;
   assign busy    = busy_r;
   assign tx_en   = busy_r;
   assign done    = done_r;
`ifdef TX_RTZ_EN
   assign pulse_clamp = clamp_r;
`else
   logic unused_s;
   assign unused_s = clamp_r;
`endif

endmodule

// File: tb/tb_tx_dbf_ch.sv
// Randomized plus directed bench for tx_dbf_ch against a per-cycle timeline model built from arithmetic.
`timescale 1ns/1ps
module tb_tx_dbf_ch;

   localparam int ADDR_WD  = 7;
   localparam int DLY_WD   = 12;
   localparam int CYC_WD   = 4;
   localparam int HP_WD    = 8;
   localparam int DAMP_CLK = 16;
   localparam int MAXC     = 6000;
`ifdef TX_RTZ_EN
   localparam bit RTZ = 1'b1;
`else
   localparam bit RTZ = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [ADDR_WD-1:0] lut_addr;
   logic [DLY_WD-1:0]  lut_din;
   logic               lut_we;
   logic [ADDR_WD-1:0] line_sel;
   logic               fire;
   logic [CYC_WD-1:0]  num_cycles;
   logic [HP_WD-1:0]   half_period;
   logic               abort;
   logic               pulse_p, pulse_n, tx_en, busy, done;
   logic               pulse_clamp_obs;
`ifdef TX_RTZ_EN
   logic               pulse_clamp;
   assign pulse_clamp_obs = pulse_clamp;
`else
   assign pulse_clamp_obs = 1'b0;
`endif

   tx_dbf_ch #(
      .ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD), .CYC_WD(CYC_WD), .HP_WD(HP_WD), .DAMP_CLK(DAMP_CLK)
   ) dut (
      .clk(clk), .rst(rst),
      .lut_addr(lut_addr), .lut_din(lut_din), .lut_we(lut_we),
      .line_sel(line_sel), .fire(fire), .num_cycles(num_cycles), .half_period(half_period),
      .abort(abort),
      .pulse_p(pulse_p), .pulse_n(pulse_n), .tx_en(tx_en), .busy(busy),
`ifdef TX_RTZ_EN
      .pulse_clamp(pulse_clamp),
`endif
      .done(done)
   );

   always #12.5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   bit e_busy [MAXC];
   bit e_p    [MAXC];
   bit e_n    [MAXC];
   bit e_done [MAXC];
   bit e_clamp[MAXC];
   int lut_m  [1 << ADDR_WD];

   task automatic chk_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic mark(input int idx, input int which);
      if (idx >= 0 && idx < MAXC) begin
         case (which)
            0: e_busy[idx] = 1'b1;
            1: e_p[idx] = 1'b1;
            2: e_n[idx] = 1'b1;
            3: e_done[idx] = 1'b1;
            default: e_clamp[idx] = 1'b1;
         endcase
      end
   endtask

   // Expected timeline of one accepted fire at cycle f with delay d.
   task automatic schedule(input int f, input int d, input int nc, input int hp);
      int h, burst, len, slot, st;
      h     = (hp == 0) ? 1 : hp;
      burst = 2 * nc * h + ((RTZ && nc > 0) ? 2 * nc - 1 : 0);
      len   = 1 + d + burst + DAMP_CLK;
      slot  = 2 * h + (RTZ ? 2 : 0);
      for (int k = 1; k <= len; k++) mark(f + k, 0);
      mark(f + len, 3);
      for (int c = 0; c < nc; c++) begin
         st = f + 2 + d + c * slot;
         for (int j = 0; j < h; j++) begin
            mark(st + j, 1);
            mark(st + h + (RTZ ? 1 : 0) + j, 2);
         end
         if (RTZ) begin
            mark(st + h, 4);
            if (c < nc - 1) mark(st + 2 * h + 1, 4);
         end
      end
      if (RTZ) begin
         for (int k = len - DAMP_CLK + 1; k <= len; k++) mark(f + k, 4);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, compare outputs at the falling edge.
   task automatic step(input bit f, input int sel, input int nc, input int hp, input bit ab,
                       input bit we, input int wa, input int wd);
      fire        = f;
      line_sel    = ADDR_WD'(sel);
      num_cycles  = CYC_WD'(nc);
      half_period = HP_WD'(hp);
      abort       = ab;
      lut_we      = we;
      lut_addr    = ADDR_WD'(wa);
      lut_din     = DLY_WD'(wd);
      if (ab && e_busy[cyc]) begin
         for (int k = cyc + 1; k < MAXC; k++) begin
            e_busy[k] = 1'b0; e_p[k] = 1'b0; e_n[k] = 1'b0; e_done[k] = 1'b0; e_clamp[k] = 1'b0;
         end
      end else if (f && !ab && !e_busy[cyc]) begin
         schedule(cyc, lut_m[sel], nc, hp);
      end
      if (we) lut_m[wa] = wd;
      @(negedge clk);
      chk_eq("busy", int'(busy), int'(e_busy[cyc]));
      chk_eq("tx_en", int'(tx_en), int'(e_busy[cyc]));
      chk_eq("pulse_p", int'(pulse_p), int'(e_p[cyc]));
      chk_eq("pulse_n", int'(pulse_n), int'(e_n[cyc]));
      chk_eq("done", int'(done), int'(e_done[cyc]));
      chk_eq("gate_overlap", int'(pulse_p & pulse_n), 0);
      if (RTZ) chk_eq("pulse_clamp", int'(pulse_clamp_obs), int'(e_clamp[cyc]));
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic shot(input int sel, input int nc, input int hp);
      step(1'b1, sel, nc, hp, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      #(MAXC * 25 * 2);
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      fire = 1'b0; abort = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_din = '0;
      line_sel = '0; num_cycles = '0; half_period = '0;
      for (int k = 0; k < MAXC; k++) begin
         e_busy[k] = 1'b0; e_p[k] = 1'b0; e_n[k] = 1'b0; e_done[k] = 1'b0; e_clamp[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_tx_en", int'(tx_en), 0);
      chk_eq("rst_pulse_p", int'(pulse_p), 0);
      chk_eq("rst_pulse_n", int'(pulse_n), 0);
      chk_eq("rst_done", int'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int a = 0; a < (1 << ADDR_WD); a++)
         step(1'b0, 0, 0, 0, 1'b0, 1'b1, a, int'($urandom_range(0, 40)));
      step(1'b0, 0, 0, 0, 1'b0, 1'b1, 5, 10);
      step(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
      step(1'b0, 0, 0, 0, 1'b0, 1'b1, 9, 3);
      idle(2);

      shot(5, 2, 4); idle(50);
      shot(0, 1, 0); idle(30);
      shot(9, 0, 7); idle(30);
      shot(5, 2, 4); idle(7); shot(5, 2, 4); idle(50);
      shot(5, 2, 4); idle(13);
      step(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
      idle(5); shot(5, 2, 4); idle(50);
      step(1'b1, 5, 2, 4, 1'b0, 1'b1, 5, 20); idle(50);
      shot(5, 2, 4); idle(70);

      while (cyc < MAXC - 400) begin
         step($urandom_range(0, 24) == 0, int'($urandom_range(0, 127)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              $urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, 127)), int'($urandom_range(0, 40)));
      end
      idle(150);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
